// File: rtl/dht11_frame_rx.sv
// dht11_frame_rx: assembles 6-byte DHT11 frames (sync, hum int/dec, temp int/dec, checksum)
// from a UART byte stream, validates the checksum, enforces an inter-byte timeout and
// publishes the most recent good reading.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_byte, rx_done    received byte and its one-cycle valid strobe
//   hum_int, hum_dec    humidity of last good frame
//   temp_int, temp_dec  temperature of last good frame
//   frame_valid         one-cycle pulse: published reading just updated
//   chk_err             one-cycle pulse: checksum mismatch, reading unchanged
//   timeout_err         one-cycle pulse: frame abandoned after inter-byte timeout
//   busy                high while a frame is being assembled
//   good_cnt, bad_cnt   saturating frame statistics (only with FRAME_STATS_EN)
//
// Build option: define FRAME_STATS_EN to add the good_cnt/bad_cnt counters and ports.
module dht11_frame_rx #(
    parameter int unsigned CLK_FREQ       = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 4000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_done,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] temp_int,
    output logic [7:0] temp_dec,
    output logic       frame_valid,
    output logic       chk_err,
    output logic       timeout_err,
    output logic       busy
`ifdef FRAME_STATS_EN
    ,
    output logic [7:0] good_cnt,
    output logic [7:0] bad_cnt
`endif
);

    // TIMEOUT_CYCLES is normally derived from CLK_FREQ and the sensor's byte period.
    if (CLK_FREQ == 0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("dht11_frame_rx: CLK_FREQ must be nonzero and TIMEOUT_CYCLES at least 2");
    end

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic [7:0] hum_int;
        logic [7:0] hum_dec;
        logic [7:0] temp_int;
        logic [7:0] temp_dec;
    } reading_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HUM_I = 3'd1,
        S_HUM_D = 3'd2,
        S_TMP_I = 3'd3,
        S_TMP_D = 3'd4,
        S_CHK   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    reading_t         shadow_q, shadow_d;
    reading_t         out_q, out_d;
    logic             fv_q, fv_d;
    logic             ce_q, ce_d;
    logic             to_q, to_d;
    logic             busy_q, busy_d;
    logic [7:0]       chk_sum;
    logic             timeout_hit;

`ifdef FRAME_STATS_EN
    logic [7:0] good_q, good_d;
    logic [7:0] bad_q, bad_d;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            out_q    <= '0;
            fv_q     <= 1'b0;
            ce_q     <= 1'b0;
            to_q     <= 1'b0;
            busy_q   <= 1'b0;
`ifdef FRAME_STATS_EN
            good_q   <= '0;
            bad_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            fv_q     <= fv_d;
            ce_q     <= ce_d;
            to_q     <= to_d;
            busy_q   <= busy_d;
`ifdef FRAME_STATS_EN
            good_q   <= good_d;
            bad_q    <= bad_d;
`endif
        end
    end

    // Next-state, frame assembly, checksum and timeout decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        fv_d     = 1'b0;
        ce_d     = 1'b0;
        to_d     = 1'b0;

        chk_sum = 8'(shadow_q.hum_int + shadow_q.hum_dec + shadow_q.temp_int + shadow_q.temp_dec);
        // A byte arriving on the terminal-count cycle still counts as in time.
        timeout_hit = (state_q != S_IDLE) && !rx_done && (cnt_q == TERM_CNT);

        if (state_q != S_IDLE) begin
            cnt_d = rx_done ? '0 : cnt_q + CNT_W'(1);
        end

        if (timeout_hit) begin
            to_d     = 1'b1;
            state_d  = S_IDLE;
            shadow_d = '0;
            cnt_d    = '0;
        end else if (rx_done) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = S_HUM_I;
                        cnt_d   = '0;
                    end
                end
                S_HUM_I: begin
                    shadow_d.hum_int = rx_byte;
                    state_d          = S_HUM_D;
                end
                S_HUM_D: begin
                    shadow_d.hum_dec = rx_byte;
                    state_d          = S_TMP_I;
                end
                S_TMP_I: begin
                    shadow_d.temp_int = rx_byte;
                    state_d           = S_TMP_D;
                end
                S_TMP_D: begin
                    shadow_d.temp_dec = rx_byte;
                    state_d           = S_CHK;
                end
                S_CHK: begin
                    if (rx_byte == chk_sum) begin
                        out_d = shadow_q;
                        fv_d  = 1'b1;
                    end else begin
                        ce_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

`ifdef FRAME_STATS_EN
    // Saturating good/bad frame counters.
    always_comb begin
        good_d = good_q;
        bad_d  = bad_q;
        if (fv_d && (good_q != 8'hFF)) begin
            good_d = good_q + 8'd1;
        end
        if ((ce_d || to_d) && (bad_q != 8'hFF)) begin
            bad_d = bad_q + 8'd1;
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`endif

    assign hum_int     = out_q.hum_int;
    assign hum_dec     = out_q.hum_dec;
    assign temp_int    = out_q.temp_int;
    assign temp_dec    = out_q.temp_dec;
    assign frame_valid = fv_q;
    assign chk_err     = ce_q;
    assign timeout_err = to_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dht11_frame_rx.sv
// Testbench for dht11_frame_rx: scenario tasks plus randomized byte streams checked every
// cycle against a frame-level reference model (byte queue + idle-cycle count).
module tb_dht11_frame_rx;

    localparam int unsigned T    = 40;
    localparam logic [7:0]  SYNC = 8'hAA;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
    logic       frame_valid, chk_err, timeout_err, busy;
`ifdef FRAME_STATS_EN
    logic [7:0] good_cnt, bad_cnt;
`endif

    always #5 clk = ~clk;

    dht11_frame_rx #(
        .TIMEOUT_CYCLES(T),
        .SYNC_BYTE     (SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_byte    (rx_byte),
        .rx_done    (rx_done),
        .hum_int    (hum_int),
        .hum_dec    (hum_dec),
        .temp_int   (temp_int),
        .temp_dec   (temp_dec),
        .frame_valid(frame_valid),
        .chk_err    (chk_err),
        .timeout_err(timeout_err),
        .busy       (busy)
`ifdef FRAME_STATS_EN
        ,
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    bit           m_in_frame = 0;
    byte unsigned m_buf[$];
    int           m_idle = 0;
    logic [31:0]  m_out = '0;
    logic [3:0]   m_flags = '0;
    int           m_good = 0;
    int           m_bad = 0;

    // Stimulus queues: byte and number of idle cycles before it.
    byte unsigned q_b[$];
    int           q_g[$];

    function automatic logic [35:0] observed();
        return {frame_valid, chk_err, timeout_err, busy, hum_int, hum_dec, temp_int, temp_dec};
    endfunction

    // Drive one cycle and advance the model by the same cycle.
    task automatic tick(input bit done, input logic [7:0] b);
        int s;
        bit fv, ce, to;
        rx_done = done;
        rx_byte = done ? b : 8'($urandom);
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        fv = 0; ce = 0; to = 0;
        if (m_in_frame) begin
            if (done) begin
                m_idle = 0;
                m_buf.push_back(b);
                if (m_buf.size() == 5) begin
                    s = 0;
                    for (int i = 0; i < 4; i++) s += m_buf[i];
                    if ((s % 256) == int'(m_buf[4])) begin
                        m_out = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
                        fv = 1;
                        m_good++;
                    end else begin
                        ce = 1;
                        m_bad++;
                    end
                    m_in_frame = 0;
                    m_buf.delete();
                end
            end else begin
                m_idle++;
                if (m_idle == int'(T)) begin
                    to = 1;
                    m_bad++;
                    m_in_frame = 0;
                    m_buf.delete();
                end
            end
        end else if (done && b == SYNC) begin
            m_in_frame = 1;
            m_idle = 0;
            m_buf.delete();
        end
        m_flags = {fv, ce, to, m_in_frame};
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        m_in_frame = 0;
        m_buf.delete();
        m_idle = 0;
        m_out = '0;
        m_flags = '0;
        m_good = 0;
        m_bad = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add(input logic [7:0] b, input int gap);
        q_b.push_back(b);
        q_g.push_back(gap);
    endtask

    task automatic add_frame(input logic [7:0] hi, input logic [7:0] hd, input logic [7:0] ti,
                             input logic [7:0] td, input logic [7:0] ck, input int gap);
        add(SYNC, gap); add(hi, gap); add(hd, gap); add(ti, gap); add(td, gap); add(ck, gap);
    endtask

    function automatic int pick_gap();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 6) return int'($urandom_range(0, 3));
        if (r == 7) return int'(T) - 1;
        if (r == 8) return int'(T);
        return int'(T) + int'($urandom_range(1, 3));
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (observed() !== 36'h0) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", observed(), 36'h0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_good_frame();
        q_b.delete(); q_g.delete();
        add(8'h00, 2);
        add_frame(8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 1);
        add(8'h00, 3);
        for (int i = 0; i < q_b.size(); i++) begin
            for (int g = 0; g <= q_g[i]; g++) begin
                tick(g == q_g[i], q_b[i]);
                n_vec++;
                if (observed() !== {m_flags, m_out}) begin
                    n_err++;
                    $display("FAIL good_frame byte %0d: got %h want %h", i, observed(), {m_flags, m_out});
                end
            end
        end
        n_vec++;
        if ({hum_int, hum_dec, temp_int, temp_dec} !== 32'h37001905) begin
            n_err++;
            $display("FAIL good_frame_value: got %h want 37001905", {hum_int, hum_dec, temp_int, temp_dec});
        end
    endtask

    task automatic test_bad_checksum();
        int ce_seen = 0;
        q_b.delete(); q_g.delete();
        add_frame(8'h37, 8'h00, 8'h19, 8'h05, 8'h54, 2);
        add(8'h00, 2);
        for (int i = 0; i < q_b.size(); i++) begin
            for (int g = 0; g <= q_g[i]; g++) begin
                tick(g == q_g[i], q_b[i]);
                ce_seen += int'(chk_err);
                n_vec++;
                if (observed() !== {m_flags, m_out}) begin
                    n_err++;
                    $display("FAIL bad_checksum byte %0d: got %h want %h", i, observed(), {m_flags, m_out});
                end
            end
        end
        n_vec++;
        if ({hum_int, hum_dec, temp_int, temp_dec} !== 32'h37001905 || ce_seen != 1) begin
            n_err++;
            $display("FAIL bad_checksum_hold: got %h chk_err pulses %0d want 37001905 and 1",
                     {hum_int, hum_dec, temp_int, temp_dec}, ce_seen);
        end
    endtask

    task automatic test_timeout();
        int to_seen = 0;
        q_b.delete(); q_g.delete();
        add(SYNC, 1); add(8'h37, 1);
        add_frame(8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 0);
        q_g[2] = int'(T) + 2;
        for (int i = 0; i < q_b.size(); i++) begin
            for (int g = 0; g <= q_g[i]; g++) begin
                tick(g == q_g[i], q_b[i]);
                to_seen += int'(timeout_err);
                n_vec++;
                if (observed() !== {m_flags, m_out}) begin
                    n_err++;
                    $display("FAIL timeout byte %0d gap %0d: got %h want %h", i, g, observed(), {m_flags, m_out});
                end
            end
        end
        n_vec++;
        if ({hum_int, hum_dec, temp_int, temp_dec} !== 32'h10002000 || to_seen != 1) begin
            n_err++;
            $display("FAIL timeout_recover: got %h timeout pulses %0d want 10002000 and 1",
                     {hum_int, hum_dec, temp_int, temp_dec}, to_seen);
        end
    endtask

    task automatic test_junk_sync();
        q_b.delete(); q_g.delete();
        add(8'h12, 1); add(8'h34, 1); add(8'hAA, 1); add(8'hAA, 1);
        add(8'h00, 1); add(8'h00, 1); add(8'h00, 1); add(8'hAA, 1);
        for (int i = 0; i < q_b.size(); i++) begin
            for (int g = 0; g <= q_g[i]; g++) begin
                tick(g == q_g[i], q_b[i]);
                n_vec++;
                if (observed() !== {m_flags, m_out}) begin
                    n_err++;
                    $display("FAIL junk_sync byte %0d: got %h want %h", i, observed(), {m_flags, m_out});
                end
            end
        end
        n_vec++;
        if ({frame_valid, hum_int, hum_dec, temp_int, temp_dec} !== 33'h1_AA000000) begin
            n_err++;
            $display("FAIL junk_sync_value: got %h want 1aa000000", {frame_valid, hum_int, hum_dec, temp_int, temp_dec});
        end
    endtask

    task automatic test_terminal_boundary();
        int to_seen = 0;
        q_b.delete(); q_g.delete();
        add_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, int'(T) - 1);
        q_g[0] = 1;
        for (int i = 0; i < q_b.size(); i++) begin
            for (int g = 0; g <= q_g[i]; g++) begin
                tick(g == q_g[i], q_b[i]);
                to_seen += int'(timeout_err);
                n_vec++;
                if (observed() !== {m_flags, m_out}) begin
                    n_err++;
                    $display("FAIL boundary byte %0d gap %0d: got %h want %h", i, g, observed(), {m_flags, m_out});
                end
            end
        end
        n_vec++;
        if ({hum_int, hum_dec, temp_int, temp_dec} !== 32'h01020304 || to_seen != 0) begin
            n_err++;
            $display("FAIL boundary_value: got %h timeout pulses %0d want 01020304 and 0",
                     {hum_int, hum_dec, temp_int, temp_dec}, to_seen);
        end
    endtask

    task automatic test_reset_midframe();
        q_b.delete(); q_g.delete();
        add(SYNC, 1); add(8'h11, 0); add(8'h22, 2);
        for (int i = 0; i < q_b.size(); i++) begin
            for (int g = 0; g <= q_g[i]; g++) begin
                tick(g == q_g[i], q_b[i]);
                n_vec++;
                if (observed() !== {m_flags, m_out}) begin
                    n_err++;
                    $display("FAIL reset_mid pre byte %0d: got %h want %h", i, observed(), {m_flags, m_out});
                end
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (observed() !== 36'h0) begin
            n_err++;
            $display("FAIL reset_mid_async: got %h want %h", observed(), 36'h0);
        end
        do_reset();
        q_b.delete(); q_g.delete();
        add_frame(8'h01, 8'h01, 8'h01, 8'h01, 8'h04, 1);
        for (int i = 0; i < q_b.size(); i++) begin
            for (int g = 0; g <= q_g[i]; g++) begin
                tick(g == q_g[i], q_b[i]);
                n_vec++;
                if (observed() !== {m_flags, m_out}) begin
                    n_err++;
                    $display("FAIL reset_mid post byte %0d: got %h want %h", i, observed(), {m_flags, m_out});
                end
            end
        end
        n_vec++;
        if ({frame_valid, hum_int, hum_dec, temp_int, temp_dec} !== 33'h1_01010101) begin
            n_err++;
            $display("FAIL reset_mid_value: got %h want 101010101", {frame_valid, hum_int, hum_dec, temp_int, temp_dec});
        end
    endtask

    task automatic test_back_to_back();
        int fv_seen = 0;
        q_b.delete(); q_g.delete();
        add_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 0);
        add_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h1A, 0);
        for (int i = 0; i < q_b.size(); i++) begin
            for (int g = 0; g <= q_g[i]; g++) begin
                tick(g == q_g[i], q_b[i]);
                fv_seen += int'(frame_valid);
                n_vec++;
                if (observed() !== {m_flags, m_out}) begin
                    n_err++;
                    $display("FAIL back_to_back byte %0d: got %h want %h", i, observed(), {m_flags, m_out});
                end
            end
        end
        n_vec++;
        if ({hum_int, hum_dec, temp_int, temp_dec} !== 32'h05060708 || fv_seen != 2) begin
            n_err++;
            $display("FAIL back_to_back_value: got %h frame_valid pulses %0d want 05060708 and 2",
                     {hum_int, hum_dec, temp_int, temp_dec}, fv_seen);
        end
    endtask

    task automatic test_random();
        logic [7:0] d [4];
        logic [7:0] ck;
        q_b.delete(); q_g.delete();
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 4) == 0) add(8'($urandom_range(0, 8'hA9)), pick_gap());
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
            ck = 8'(d[0] + d[1] + d[2] + d[3]);
            if ($urandom_range(0, 9) < 3) ck = ck + 8'($urandom_range(1, 255));
            add(SYNC, pick_gap());
            for (int k = 0; k < 4; k++) add(d[k], pick_gap());
            add(ck, pick_gap());
        end
        for (int i = 0; i < q_b.size(); i++) begin
            for (int g = 0; g <= q_g[i]; g++) begin
                tick(g == q_g[i], q_b[i]);
                n_vec++;
                if (observed() !== {m_flags, m_out}) begin
                    n_err++;
                    $display("FAIL random byte %0d gap %0d: got %h want %h", i, g, observed(), {m_flags, m_out});
                end
            end
        end
    endtask

`ifdef FRAME_STATS_EN
    task automatic test_stats();
        do_reset();
        q_b.delete(); q_g.delete();
        add_frame(8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 0);
        add_frame(8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 1);
        add_frame(8'h37, 8'h00, 8'h19, 8'h05, 8'h54, 0);
        add(SYNC, 0); add(8'h37, 0); add(8'h00, int'(T) + 1);
        for (int i = 0; i < q_b.size(); i++) begin
            for (int g = 0; g <= q_g[i]; g++) begin
                tick(g == q_g[i], q_b[i]);
                n_vec++;
                if (observed() !== {m_flags, m_out}) begin
                    n_err++;
                    $display("FAIL stats_mix byte %0d: got %h want %h", i, observed(), {m_flags, m_out});
                end
            end
        end
        n_vec++;
        if ({good_cnt, bad_cnt} !== 16'h0202) begin
            n_err++;
            $display("FAIL stats_mix_counts: got good %0d bad %0d want 2 2", good_cnt, bad_cnt);
        end
        q_b.delete(); q_g.delete();
        for (int f = 0; f < 300; f++) add_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 0);
        for (int i = 0; i < q_b.size(); i++) begin
            tick(1'b1, q_b[i]);
        end
        n_vec++;
        if ({good_cnt, bad_cnt} !== {8'hFF, 8'(m_bad)} || m_good != 302) begin
            n_err++;
            $display("FAIL stats_saturate: got good %0d bad %0d want 255 %0d", good_cnt, bad_cnt, m_bad);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_timeout();
        test_junk_sync();
        test_terminal_boundary();
        test_reset_midframe();
        test_back_to_back();
        test_random();
`ifdef FRAME_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
